// File: rtl/tmu2_mpram_pkg.sv
// Geometry helpers for the TMU2 multi-port texel RAM.
// The widths depend on instance parameters, so they are functions, not fixed localparams.
package tmu2_mpram_pkg;

  // Entry address width of one half-line bank.
  function automatic int entry_aw(input int depth, input int lw);
    return depth - $clog2(lw / 16);
  endfunction

  // Width of the texel select within a half-line.
  function automatic int sel_w(input int lw, input int tw);
    return $clog2(lw / (2 * tw));
  endfunction

  // Byte-offset bits below one texel.
  function automatic int boff_w(input int tw);
    return $clog2(tw / 8);
  endfunction

  // Byte-offset bits below one full cache line.
  function automatic int line_ow(input int lw);
    return $clog2(lw / 8);
  endfunction

  // Number of dual-port banks for a given read port count.
  function automatic int bank_cnt(input int nports);
    return nports / 2;
  endfunction

endpackage

// File: rtl/tmu2_mpram_bank.sv
// True dual-port half-line RAM with a shared clock enable and registered read data.
// Both ports write together (one line fill); reads update the outputs only on re_i.
module tmu2_mpram_bank #(
  parameter int AW = 7,
  parameter int DW = 128
) (
  input  logic          clk_i,
  input  logic          ce_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] a_wd_i,
  input  logic [DW-1:0] b_wd_i,
  output logic [DW-1:0] a_rd_o,
  output logic [DW-1:0] b_rd_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] a_rd_q;
  logic [DW-1:0] b_rd_q;

  // Outputs hold whenever ce_i is low or no read is granted, so stalled data stays stable.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (we_i) begin
        mem_q[a_addr_i] <= a_wd_i;
        mem_q[b_addr_i] <= b_wd_i;
      end else if (re_i) begin
        a_rd_q <= mem_q[a_addr_i];
        b_rd_q <= mem_q[b_addr_i];
      end
    end
  end

  assign a_rd_o = a_rd_q;
  assign b_rd_o = b_rd_q;

endmodule

// File: rtl/tmu2_mpram.sv
// TMU2 texel cache RAM: one line-write port, nports lockstep texel read ports,
// stb/ack handshake with backpressure, write-priority arbitration, optional output register.
module tmu2_mpram
  import tmu2_mpram_pkg::*;
#(
  parameter int depth  = 11,
  parameter int nports = 4,
  parameter int tw     = 16,
  parameter int lw     = 256,
  parameter int outreg = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      r_stb,
  output logic                      r_ack,
  input  logic [nports*depth-1:0]   ra,
  output logic                      rd_stb,
  input  logic                      rd_ack,
  output logic [nports*tw-1:0]      rd,
  input  logic                      w_stb,
  output logic                      w_ack,
  input  logic [depth-1:0]          wa,
  input  logic [lw-1:0]             wd
);

  localparam int EAW  = entry_aw(depth, lw);
  localparam int HO   = depth - EAW;
  localparam int SW   = sel_w(lw, tw);
  localparam int BW   = boff_w(tw);
  localparam int LOW  = line_ow(lw);
  localparam int HW   = lw / 2;
  localparam int NB   = bank_cnt(nports);
  localparam int NSEL = 2 ** SW;

  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic                  adv1, adv2;
  logic [HW-1:0]         half_rd [nports];
  logic [nports*tw-1:0]  mux_rd;
  logic [EAW-1:0]        w_addr_a, w_addr_b;
  logic                  unused_wa;

  // Without the output register v2 never sets, so adv2 stays high and is ignored.
  always_comb begin
    adv2  = !v2_q || rd_ack;
    adv1  = (outreg != 0) ? (!v1_q || adv2) : (!v1_q || rd_ack);
    w_ack = w_stb && adv1;
    r_ack = r_stb && adv1 && !w_stb;
    v1_d  = adv1 ? r_ack : v1_q;
    v2_d  = ((outreg != 0) && adv2) ? v1_q : v2_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign rd_stb    = (outreg != 0) ? v2_q : v1_q;
  assign w_addr_a  = {wa[depth-1:LOW], 1'b0};
  assign w_addr_b  = {wa[depth-1:LOW], 1'b1};
  assign unused_wa = ^wa[LOW-1:0];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [EAW-1:0] addr_a, addr_b;

    assign addr_a = w_ack ? w_addr_a : ra[(2*b)*depth + HO +: EAW];
    assign addr_b = w_ack ? w_addr_b : ra[(2*b+1)*depth + HO +: EAW];

    tmu2_mpram_bank #(
      .AW (EAW),
      .DW (HW)
    ) u_bank (
      .clk_i    (sys_clk),
      .ce_i     (adv1),
      .we_i     (w_ack),
      .re_i     (r_ack),
      .a_addr_i (addr_a),
      .b_addr_i (addr_b),
      .a_wd_i   (wd[lw-1 -: HW]),
      .b_wd_i   (wd[HW-1:0]),
      .a_rd_o   (half_rd[2*b]),
      .b_rd_o   (half_rd[2*b+1])
    );
  end

  for (genvar i = 0; i < nports; i++) begin : g_port
    if (SW > 0) begin : g_sel
      logic [SW-1:0] sel_q, sel_d;
      logic [tw-1:0] tex;

      // Select tracks the RAM output: it only moves when a new read is granted.
      assign sel_d = r_ack ? ra[i*depth + BW +: SW] : sel_q;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sel_q <= '0;
        else            sel_q <= sel_d;
      end

      always_comb begin
        tex = '0;
        for (int s = 0; s < NSEL; s++) begin
          if (sel_q == SW'(s)) tex = half_rd[i][HW-1-s*tw -: tw];
        end
      end

      assign mux_rd[i*tw +: tw] = tex;
    end else begin : g_nosel
      assign mux_rd[i*tw +: tw] = half_rd[i][HW-1 -: tw];
    end

    if (BW > 0) begin : g_boff
      logic unused_boff;
      assign unused_boff = ^ra[i*depth +: BW];
    end
  end

  if (outreg != 0) begin : g_oreg
    logic [nports*tw-1:0] rd_q, rd_d;

    assign rd_d = adv2 ? mux_rd : rd_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rd_q <= '0;
      else            rd_q <= rd_d;
    end

    assign rd = rd_q;
  end else begin : g_noreg
    assign rd = mux_rd;
  end

endmodule
